// File: rtl/ecc_operand_serializer_pkg.sv
// Shared definitions for the ECC operand serializer.
//   ECC_SIZE / ECC_NIB_W : default operand width and per-lane nibble width
//   HDR_BEATS            : length of the i_start frame header, in beats
//   ser_state_e          : frame FSM state encoding
package ecc_operand_serializer_pkg;

    localparam int ECC_SIZE  = 32;
    localparam int ECC_NIB_W = 4;
    localparam int HDR_BEATS = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } ser_state_e;

endpackage

// File: rtl/ecc_operand_serializer_if.sv
// Host/core bus of the ECC operand serializer.
//   Host side : i_valid, o_ready and the five full-width operands.
//   Core side : o_start header pulse and five NIB_W-wide serial lanes.
//   Status    : o_busy (accept through end of gap), o_frame_done (last cycle pulse).
// master = host/core side driving the operands, slave = the serializer.
interface ecc_operand_serializer_if
    import ecc_operand_serializer_pkg::*;
#(
    parameter int SIZE  = ECC_SIZE,
    parameter int NIB_W = ECC_NIB_W
);
    logic             i_valid;
    logic             o_ready;
    logic [SIZE-1:0]  i_a;
    logic [SIZE-1:0]  i_prime;
    logic [SIZE-1:0]  i_px;
    logic [SIZE-1:0]  i_py;
    logic [SIZE-1:0]  i_k;
    logic             o_start;
    logic [NIB_W-1:0] o_a;
    logic [NIB_W-1:0] o_prime;
    logic [NIB_W-1:0] o_px;
    logic [NIB_W-1:0] o_py;
    logic [NIB_W-1:0] o_k;
    logic             o_busy;
    logic             o_frame_done;

    modport master (
        output i_valid, i_a, i_prime, i_px, i_py, i_k,
        input  o_ready, o_start, o_a, o_prime, o_px, o_py, o_k, o_busy, o_frame_done
    );

    modport slave (
        input  i_valid, i_a, i_prime, i_px, i_py, i_k,
        output o_ready, o_start, o_a, o_prime, o_px, o_py, o_k, o_busy, o_frame_done
    );

endinterface

// File: rtl/ecc_nibble_shreg.sv
// Parallel-load, nibble-wide left shift register for one operand lane.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : capture i_din (operand accept)
//   i_shift      : the next cycle is a SEND beat; present the MS nibble and shift
//   i_din        : full-width operand
//   o_lane       : registered lane output, zero whenever no beat is being sent
module ecc_nibble_shreg
    import ecc_operand_serializer_pkg::*;
#(
    parameter int SIZE  = ECC_SIZE,
    parameter int NIB_W = ECC_NIB_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [SIZE-1:0]  i_din,
    output logic [NIB_W-1:0] o_lane
);

    logic [SIZE-1:0] sh;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sh     <= '0;
            o_lane <= '0;
        end else begin
            if (i_load) begin
                sh <= i_din;
            end else if (i_shift) begin
                sh <= sh << NIB_W;
            end
            // Lane is forced to zero outside beats so the core never sees stray nibbles.
            o_lane <= i_shift ? sh[SIZE-1 -: NIB_W] : '0;
        end
    end

endmodule

// File: rtl/ecc_operand_serializer.sv
// Host-side transmitter for the ECC scalar-multiply core's nibble-serial port.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : operand handshake in, header pulse and five serial lanes out,
//                  busy / frame-done status.
// Frame: one header beat (o_start), SIZE/NIB_W beats MS nibble first, then
// GAP_CYCLES idle cycles while the core computes, then ready again.
module ecc_operand_serializer
    import ecc_operand_serializer_pkg::*;
#(
    parameter int SIZE       = ECC_SIZE,
    parameter int NIB_W      = ECC_NIB_W,
    parameter int GAP_CYCLES = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    ecc_operand_serializer_if.slave  bus
);

    localparam int BEATS   = SIZE / NIB_W;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GAP_MAX = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX);

    ser_state_e        state, state_n;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic              accept;
    logic              shift_en;
    logic              done_n;

    assign bus.o_ready = (state == IDLE) && !i_rst;
    assign accept      = bus.i_valid && bus.o_ready;
    assign shift_en    = (state_n == SEND);

    always_comb begin
        state_n    = state;
        beat_cnt_n = '0;
        gap_cnt_n  = '0;
        done_n     = 1'b0;
        case (state)
            IDLE: if (accept) state_n = HDR;
            HDR:  state_n = SEND;
            SEND: begin
                if (beat_cnt == BEAT_LAST) begin
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    beat_cnt_n = beat_cnt + 1'b1;
                end
            end
            GAP: begin
                // Leaves on the last count, so the counter never wraps.
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered, so the pulse is decoded from the upcoming cycle.
        done_n = ((state_n == GAP) && (gap_cnt_n == GAP_LAST)) ||
                 ((GAP_CYCLES == 0) && (state_n == SEND) && (beat_cnt_n == BEAT_LAST));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= IDLE;
            beat_cnt         <= '0;
            gap_cnt          <= '0;
            bus.o_start      <= 1'b0;
            bus.o_busy       <= 1'b0;
            bus.o_frame_done <= 1'b0;
        end else begin
            state            <= state_n;
            beat_cnt         <= beat_cnt_n;
            gap_cnt          <= gap_cnt_n;
            bus.o_start      <= (state_n == HDR);
            bus.o_busy       <= (state_n != IDLE);
            bus.o_frame_done <= done_n;
        end
    end

    ecc_nibble_shreg #(.SIZE(SIZE), .NIB_W(NIB_W)) u_sh_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(accept), .i_shift(shift_en),
        .i_din(bus.i_a), .o_lane(bus.o_a)
    );
    ecc_nibble_shreg #(.SIZE(SIZE), .NIB_W(NIB_W)) u_sh_prime (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(accept), .i_shift(shift_en),
        .i_din(bus.i_prime), .o_lane(bus.o_prime)
    );
    ecc_nibble_shreg #(.SIZE(SIZE), .NIB_W(NIB_W)) u_sh_px (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(accept), .i_shift(shift_en),
        .i_din(bus.i_px), .o_lane(bus.o_px)
    );
    ecc_nibble_shreg #(.SIZE(SIZE), .NIB_W(NIB_W)) u_sh_py (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(accept), .i_shift(shift_en),
        .i_din(bus.i_py), .o_lane(bus.o_py)
    );
    ecc_nibble_shreg #(.SIZE(SIZE), .NIB_W(NIB_W)) u_sh_k (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(accept), .i_shift(shift_en),
        .i_din(bus.i_k), .o_lane(bus.o_k)
    );

endmodule

// File: tb/tb_ecc_operand_serializer.sv
// Bench for ecc_operand_serializer: one instance with a 4-cycle gap (index 0)
// and one with no gap (index 1), sharing clock, reset and operand buses.
module tb_ecc_operand_serializer;

    localparam int NONE = -100000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v4  = 1'b0;
    logic        v0  = 1'b0;
    logic [31:0] ia = '0, ip = '0, ix = '0, iy = '0, ik = '0;

    always #5 clk = ~clk;

    ecc_operand_serializer_if #(.SIZE(32), .NIB_W(4)) bus4 ();
    ecc_operand_serializer_if #(.SIZE(32), .NIB_W(4)) bus0 ();

    assign bus4.i_valid = v4;
    assign bus4.i_a = ia;  assign bus4.i_prime = ip;  assign bus4.i_px = ix;
    assign bus4.i_py = iy; assign bus4.i_k = ik;
    assign bus0.i_valid = v0;
    assign bus0.i_a = ia;  assign bus0.i_prime = ip;  assign bus0.i_px = ix;
    assign bus0.i_py = iy; assign bus0.i_k = ik;

    ecc_operand_serializer #(.SIZE(32), .NIB_W(4), .GAP_CYCLES(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .bus(bus4.slave)
    );
    ecc_operand_serializer #(.SIZE(32), .NIB_W(4), .GAP_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0.slave)
    );

    // Reference model: accept cycle and operands latched at accept, per instance.
    int          cyc     = 0;
    int          acc[2]  = '{NONE, NONE};
    int          gapv[2] = '{4, 0};
    logic [31:0] lat[2][5];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic exp_ready(int d);
        return !rst && ((cyc - acc[d]) >= 10 + gapv[d]);
    endfunction

    // Packed {ready, start, busy, done, a, prime, px, py, k}.
    function automatic logic [23:0] exp_out(int d);
        logic [23:0] e;
        int t;
        e = '0;
        if (rst) return e;
        t = cyc - acc[d];
        if (t >= 10 + gapv[d]) begin
            e[23] = 1'b1;
            return e;
        end
        e[22] = (t == 1);
        e[21] = 1'b1;
        e[20] = (t == 9 + gapv[d]);
        if (t >= 2 && t <= 9)
            for (int f = 0; f < 5; f++)
                e[19-4*f -: 4] = 4'((lat[d][f] >> (4 * (9 - t))) & 32'hF);
        return e;
    endfunction

    function automatic logic [23:0] act_out(int d);
        if (d == 0)
            return {bus4.o_ready, bus4.o_start, bus4.o_busy, bus4.o_frame_done,
                    bus4.o_a, bus4.o_prime, bus4.o_px, bus4.o_py, bus4.o_k};
        return {bus0.o_ready, bus0.o_start, bus0.o_busy, bus0.o_frame_done,
                bus0.o_a, bus0.o_prime, bus0.o_px, bus0.o_py, bus0.o_k};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            acc[0] = NONE;
            acc[1] = NONE;
        end else begin
            if (v4 && exp_ready(0)) begin
                acc[0] = cyc;
                lat[0] = '{ia, ip, ix, iy, ik};
            end
            if (v0 && exp_ready(1)) begin
                acc[1] = cyc;
                lat[1] = '{ia, ip, ix, iy, ik};
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("cycle_gap4", 32'(act_out(0)), 32'(exp_out(0)));
        chk("cycle_gap0", 32'(act_out(1)), 32'(exp_out(1)));
    end

    task automatic send(input int d, input logic [31:0] a, p, x, y, k);
        bit got;
        got = 1'b0;
        ia = a; ip = p; ix = x; iy = y; ik = k;
        if (d == 0) v4 = 1'b1; else v0 = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #1;
            if (acc[d] == cyc - 1) got = 1'b1;
        end
        v4 = 1'b0;
        v0 = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Called in the header cycle; collects the prime/k lanes and the frame_done offset.
    task automatic capture(input int d, output logic [31:0] cp, output logic [31:0] ck,
                           output int done_off);
        logic [23:0] o;
        cp = '0; ck = '0; done_off = -1;
        @(negedge clk);
        o = act_out(d);
        chk("hdr_start", 32'(o[22]), 32'd1);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            o = act_out(d);
            if (b == 0) chk("start_one_cycle", 32'(o[22]), 32'd0);
            cp = {cp[27:0], o[15:12]};
            ck = {ck[27:0], o[3:0]};
        end
        for (int j = 9; j < 40 && done_off < 0; j++) begin
            if (j > 9) @(negedge clk);
            if (act_out(d)[20]) done_off = j;
        end
    endtask

    typedef struct {
        logic [31:0] a, p, x, y, k;
        logic [31:0] exp_p, exp_k;
        int          exp_done;
    } vec_t;

    vec_t tbl[3];

    initial begin
        logic [31:0] cp, ck;
        int          off, s1, s2;
        bit          seen;

        tbl[0] = '{32'h2, 32'h11, 32'h5, 32'h1, 32'h9, 32'h00000011, 32'h00000009, 13};
        tbl[1] = '{32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF,
                   32'h89ABCDEF, 32'h89ABCDEF, 13};
        tbl[2] = '{32'hFFFFFFFF, 32'h80000001, 32'h0, 32'h7, 32'hF0F0F0F0,
                   32'h80000001, 32'hF0F0F0F0, 13};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(act_out(0)), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(act_out(0)[23]), 32'd1);

        for (int i = 0; i < 3; i++) begin
            send(0, tbl[i].a, tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].k);
            capture(0, cp, ck, off);
            chk($sformatf("vec%0d_prime", i), cp, tbl[i].exp_p);
            chk($sformatf("vec%0d_k", i), ck, tbl[i].exp_k);
            chk($sformatf("vec%0d_done_off", i), 32'(off), 32'(tbl[i].exp_done));
        end

        // Operand change after accept must not reach the lanes.
        send(0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h12345678);
        ik = 32'hFFFFFFFF;
        capture(0, cp, ck, off);
        chk("k_latched", ck, 32'h12345678);

        // Continuous valid with no gap: one frame every 10 cycles.
        ia = 32'hA5A5A5A5; ip = 32'h0F0F0F0F; ix = 32'h13579BDF; iy = 32'h2468ACE0; ik = 32'h31415926;
        v0 = 1'b1;
        s1 = -1; s2 = -1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (act_out(1)[22]) begin seen = 1'b1; s1 = cyc; end
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (act_out(1)[22]) begin seen = 1'b1; s2 = cyc; end
        end
        chk("frame_period", 32'(s2 - s1), 32'd10);
        v0 = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset at beat 3, then a clean frame.
        send(0, 32'hCAFEF00D, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async_out", 32'(act_out(0)), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", 32'(act_out(0)[23]), 32'd1);
        send(0, tbl[0].a, tbl[0].p, tbl[0].x, tbl[0].y, tbl[0].k);
        capture(0, cp, ck, off);
        chk("post_rst_prime", cp, tbl[0].exp_p);
        chk("post_rst_done_off", 32'(off), 32'd13);

        // Random valid and operands every cycle on both instances.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            v4 = 1'($urandom_range(0, 1));
            v0 = 1'($urandom_range(0, 1));
            ia = $urandom; ip = $urandom; ix = $urandom; iy = $urandom; ik = $urandom;
        end
        v4 = 1'b0;
        v0 = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
